// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes RX command frames into register-file, ALU and TX FIFO traffic.
// Optional inter-byte timeout abort is enabled by defining CMD_TIMEOUT_EN.
module cmd_frame_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY,
  output logic                    ERR
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, RD_SEND,
    ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, TX_LO, TX_HI, BR_ADDR, BR_CNT
  } state_t;

  state_t                  r_state, w_state;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
  logic [DATA_WIDTH-1:0]   r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0]   r_rd_data, w_rd_data;
  logic [2*DATA_WIDTH-1:0] r_alu, w_alu;

  logic [ADDR_WIDTH-1:0]   r_address, w_address;
  logic [DATA_WIDTH-1:0]   r_wr_data, w_wr_data;
  logic [3:0]              r_alu_fun, w_alu_fun;
  logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data;
  logic                    r_wr_en, w_wr_en;
  logic                    r_rd_en, w_rd_en;
  logic                    r_alu_en, w_alu_en;
  logic                    r_clk_en, w_clk_en;
  logic                    r_tx_vld, w_tx_vld;
  logic                    r_busy;
  logic                    w_tx_ok;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          w_waiting;
  logic          w_timeout;
  logic          r_err, w_err;

  always_comb begin
    w_waiting = 1'b0;
    case (r_state)
      WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, BR_ADDR, BR_CNT: w_waiting = 1'b1;
      default: w_waiting = 1'b0;
    endcase
  end

  assign w_timeout = w_waiting && !RX_D_VLD && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        r_tmo <= '0;
    else if (RX_D_VLD || !w_waiting) r_tmo <= '0;
    else                            r_tmo <= r_tmo + TW'(1);
  end
`endif

  // Spacing TX writes by one idle cycle absorbs a one-cycle lag on FIFO_FULL.
  assign w_tx_ok = !FIFO_FULL && !r_tx_vld;

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_cnt     = r_cnt;
    w_rd_data = r_rd_data;
    w_alu     = r_alu;
    w_address = r_address;
    w_wr_data = r_wr_data;
    w_alu_fun = r_alu_fun;
    w_clk_en  = r_clk_en;
    w_tx_data = r_tx_data;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_alu_en  = 1'b0;
    w_tx_vld  = 1'b0;
`ifdef CMD_TIMEOUT_EN
    w_err     = 1'b0;
`endif

    case (r_state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          DATA_WIDTH'(8'hAA): w_state = WR_ADDR;
          DATA_WIDTH'(8'hBB): w_state = RD_ADDR;
          DATA_WIDTH'(8'hCC): w_state = ALU_A;
          DATA_WIDTH'(8'hDD): begin w_state = ALU_FUNC; w_clk_en = 1'b1; end
          DATA_WIDTH'(8'hEE): w_state = BR_ADDR;
          default:            w_state = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        w_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
        w_state = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        w_wr_en   = 1'b1;
        w_address = r_addr;
        w_wr_data = RX_P_DATA;
        w_state   = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        w_addr    = RX_P_DATA[ADDR_WIDTH-1:0];
        w_cnt     = DATA_WIDTH'(1);
        w_address = RX_P_DATA[ADDR_WIDTH-1:0];
        w_rd_en   = 1'b1;
        w_state   = RD_REQ;
      end
      // RdEn is launched on entry so it is visible for the whole RD_REQ cycle.
      RD_REQ: w_state = RD_WAIT;
      RD_WAIT: if (RdData_Valid) begin
        w_rd_data = RdData;
        w_state   = RD_SEND;
      end
      RD_SEND: if (w_tx_ok) begin
        w_tx_vld  = 1'b1;
        w_tx_data = r_rd_data;
        if (r_cnt > DATA_WIDTH'(1)) begin
          w_cnt     = r_cnt - DATA_WIDTH'(1);
          w_addr    = r_addr + ADDR_WIDTH'(1);
          w_address = r_addr + ADDR_WIDTH'(1);
          w_rd_en   = 1'b1;
          w_state   = RD_REQ;
        end else begin
          w_state = IDLE;
        end
      end
      ALU_A: if (RX_D_VLD) begin
        w_wr_en   = 1'b1;
        w_address = '0;
        w_wr_data = RX_P_DATA;
        w_state   = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        w_wr_en   = 1'b1;
        w_address = ADDR_WIDTH'(1);
        w_wr_data = RX_P_DATA;
        w_clk_en  = 1'b1;
        w_state   = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        w_alu_en  = 1'b1;
        w_alu_fun = RX_P_DATA[3:0];
        w_state   = ALU_WAIT;
      end
      ALU_WAIT: if (OUT_Valid) begin
        w_alu    = ALU_OUT;
        w_clk_en = 1'b0;
        w_state  = TX_LO;
      end
      TX_LO: if (w_tx_ok) begin
        w_tx_vld  = 1'b1;
        w_tx_data = r_alu[DATA_WIDTH-1:0];
        w_state   = TX_HI;
      end
      TX_HI: if (w_tx_ok) begin
        w_tx_vld  = 1'b1;
        w_tx_data = r_alu[2*DATA_WIDTH-1:DATA_WIDTH];
        w_state   = IDLE;
      end
      BR_ADDR: if (RX_D_VLD) begin
        w_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
        w_state = BR_CNT;
      end
      BR_CNT: if (RX_D_VLD) begin
        if (RX_P_DATA == '0) begin
          w_state = IDLE;
        end else begin
          w_cnt     = RX_P_DATA;
          w_address = r_addr;
          w_rd_en   = 1'b1;
          w_state   = RD_REQ;
        end
      end
      default: w_state = IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    if (w_timeout) begin
      w_state  = IDLE;
      w_err    = 1'b1;
      w_clk_en = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_alu     <= '0;
      r_address <= '0;
      r_wr_data <= '0;
      r_alu_fun <= '0;
      r_tx_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_cnt     <= w_cnt;
      r_rd_data <= w_rd_data;
      r_alu     <= w_alu;
      r_address <= w_address;
      r_wr_data <= w_wr_data;
      r_alu_fun <= w_alu_fun;
      r_tx_data <= w_tx_data;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_alu_en  <= w_alu_en;
      r_clk_en  <= w_clk_en;
      r_tx_vld  <= w_tx_vld;
      r_busy    <= (w_state != IDLE);
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_err <= 1'b0;
    else     r_err <= w_err;
  end
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  assign Address   = r_address;
  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign WrData    = r_wr_data;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = r_alu_en;
  assign CLK_EN    = r_clk_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed self-checking bench for cmd_frame_ctrl (DATA_WIDTH=8, ADDR_WIDTH=4, TIMEOUT_CYCLES=16).
module tb_cmd_frame_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic        FIFO_FULL;
  logic [3:0]  Address;
  logic        WrEn, RdEn;
  logic [7:0]  WrData;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD, BUSY, ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cmd_frame_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .FIFO_FULL(FIFO_FULL), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp, output int at);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (TX_D_VLD !== 1'b1 && n < 40);
    at = cyc;
    chk({tag, "_vld"}, {31'd0, TX_D_VLD}, 32'd1);
    chk({tag, "_data"}, {24'd0, TX_P_DATA}, {24'd0, exp});
  endtask

  initial begin
    int t1, t2, bad, c0, err_at, wr_seen;
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
    ALU_OUT = '0; OUT_Valid = 1'b0; FIFO_FULL = 1'b0;
    tick(); tick();
    chk("reset_outputs", {1'b0, Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
                          TX_P_DATA, TX_D_VLD, BUSY, ERR}, 32'd0);
    RST = 1'b0;
    tick();

    // register write
    send_byte(8'hAA);
    chk("wr_busy", {31'd0, BUSY}, 32'd1);
    send_byte(8'h05);
    chk("wr_no_early_wren", {31'd0, WrEn}, 32'd0);
    send_byte(8'h3C);
    chk("wr_wren", {31'd0, WrEn}, 32'd1);
    chk("wr_addr", {28'd0, Address}, 32'h5);
    chk("wr_data", {24'd0, WrData}, 32'h3C);
    tick();
    chk("wr_wren_pulse", {31'd0, WrEn}, 32'd0);
    chk("wr_idle", {31'd0, BUSY}, 32'd0);

    // single read
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("rd_rden", {31'd0, RdEn}, 32'd1);
    chk("rd_addr", {28'd0, Address}, 32'h5);
    tick();
    chk("rd_rden_pulse", {31'd0, RdEn}, 32'd0);
    RdData = 8'h3C; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    wait_tx("rd_tx", 8'h3C, t1);
    chk("rd_idle", {31'd0, BUSY}, 32'd0);
    tick();
    chk("rd_tx_pulse", {31'd0, TX_D_VLD}, 32'd0);

    // ALU with operands
    send_byte(8'hCC);
    send_byte(8'h12);
    chk("alu_wa_en", {31'd0, WrEn}, 32'd1);
    chk("alu_wa_addr", {28'd0, Address}, 32'h0);
    chk("alu_wa_data", {24'd0, WrData}, 32'h12);
    send_byte(8'h34);
    chk("alu_wb_en", {31'd0, WrEn}, 32'd1);
    chk("alu_wb_addr", {28'd0, Address}, 32'h1);
    chk("alu_wb_data", {24'd0, WrData}, 32'h34);
    chk("alu_wb_clken", {31'd0, CLK_EN}, 32'd1);
    send_byte(8'h01);
    chk("alu_en", {31'd0, ALU_EN}, 32'd1);
    chk("alu_fun", {28'd0, ALU_FUN}, 32'h1);
    chk("alu_clken", {31'd0, CLK_EN}, 32'd1);
    tick();
    chk("alu_en_pulse", {31'd0, ALU_EN}, 32'd0);
    ALU_OUT = 16'hABCD; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    chk("alu_clken_drop", {31'd0, CLK_EN}, 32'd0);
    wait_tx("alu_lo", 8'hCD, t1);
    wait_tx("alu_hi", 8'hAB, t2);
    chk("alu_gap", t2 - t1, 32'd2);
    chk("alu_idle", {31'd0, BUSY}, 32'd0);
    chk("alu_fun_hold", {28'd0, ALU_FUN}, 32'h1);

    // burst read with address wrap
    send_byte(8'hEE);
    send_byte(8'h0E);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] ea;
      ea = 4'hE + 4'(i);
      chk($sformatf("br_rden_%0d", i), {31'd0, RdEn}, 32'd1);
      chk($sformatf("br_addr_%0d", i), {28'd0, Address}, {28'd0, ea});
      tick();
      RdData = 8'h50 + 8'(i); RdData_Valid = 1'b1;
      tick();
      RdData_Valid = 1'b0;
      wait_tx($sformatf("br_tx_%0d", i), 8'h50 + 8'(i), t1);
    end
    chk("br_done_rden", {31'd0, RdEn}, 32'd0);
    chk("br_done_idle", {31'd0, BUSY}, 32'd0);

    // burst of zero length
    send_byte(8'hEE);
    send_byte(8'h03);
    send_byte(8'h00);
    chk("br0_idle", {31'd0, BUSY}, 32'd0);
    chk("br0_no_rden", {31'd0, RdEn}, 32'd0);

    // back-pressure during TX_LO, with a stray byte that must be dropped
    send_byte(8'hDD);
    chk("bp_clken_entry", {31'd0, CLK_EN}, 32'd1);
    send_byte(8'h07);
    chk("bp_alu_fun", {28'd0, ALU_FUN}, 32'h7);
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send_byte(8'hAA);
      else        tick();
      if (TX_D_VLD !== 1'b0) bad++;
    end
    chk("bp_hold", bad, 32'd0);
    FIFO_FULL = 1'b0;
    wait_tx("bp_lo", 8'h34, t1);
    wait_tx("bp_hi", 8'h12, t2);
    chk("bp_gap_ge2", {31'd0, (t2 - t1) >= 2}, 32'd1);
    tick();
    chk("bp_drop_idle", {31'd0, BUSY}, 32'd0);

    // unknown command
    send_byte(8'h55);
    chk("bad_cmd_idle", {31'd0, BUSY}, 32'd0);
    chk("bad_cmd_err", {31'd0, ERR}, 32'd0);

    // stalled frame
    send_byte(8'hAA);
    send_byte(8'h05);
    c0 = cyc; err_at = -1; wr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ERR === 1'b1 && err_at < 0) err_at = cyc - c0;
      if (WrEn !== 1'b0) wr_seen++;
    end
    chk("stall_no_wren", wr_seen, 32'd0);
`ifdef CMD_TIMEOUT_EN
    chk("tmo_err_at", err_at, 32'd16);
    chk("tmo_idle", {31'd0, BUSY}, 32'd0);
    send_byte(8'h3C);
    chk("tmo_byte_ignored", {31'd0, WrEn}, 32'd0);
`else
    chk("stall_no_err", err_at, 32'hFFFF_FFFF);
    chk("stall_busy", {31'd0, BUSY}, 32'd1);
    send_byte(8'h3C);
    chk("stall_late_wren", {31'd0, WrEn}, 32'd1);
    chk("stall_late_data", {24'd0, WrData}, 32'h3C);
`endif
    tick();

    // reset while waiting for the ALU
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    tick();
    chk("rst_pre_clken", {31'd0, CLK_EN}, 32'd1);
    chk("rst_pre_busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_async", {1'b0, Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
                      TX_P_DATA, TX_D_VLD, BUSY, ERR}, 32'd0);
    tick();
    RST = 1'b0;
    ALU_OUT = 16'h9999; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (TX_D_VLD !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    chk("rst_no_tx", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
